// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-cycle data-memory responder: word RAM, console TX FIFO, compare timer
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int CW  = FPW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [2:0] REG_CONSOLE = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_TIMER   = 3'd2;
  localparam logic [2:0] REG_CMP     = 3'd3;
  localparam logic [2:0] REG_CTRL    = 3'd4;

  logic [31:0]    ram_mem [DEPTH_WORDS];
  logic [7:0]     fifo_mem [FIFO_DEPTH];

  logic [FPW-1:0] wptr_q, wptr_d;
  logic [FPW-1:0] rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [31:0]    timer_q, timer_d;
  logic [31:0]    cmp_q, cmp_d;
  logic           en_q, en_d;
  logic           pend_q, pend_d;
  logic           irqen_q, irqen_d;
  logic           irq_q;
  logic           bus_err_q;

  logic           ram_hit, per_hit, mapped, misaligned, illegal, wr_ok;
  logic [2:0]     reg_idx;
  logic [AW-1:0]  ram_idx;
  logic           fifo_full, fifo_empty, pop, push_req, push_acc;
  logic [4:0]     count5;

  // Address decode: RAM occupies the bottom of the map, peripherals sit at 0x8000_0000..0x8000_0010
  always_comb begin
    ram_hit    = (Addr[31:AW+2] == '0);
    per_hit    = (Addr[31:5] == 27'h400_0000) && (Addr[4:2] <= REG_CTRL);
    mapped     = ram_hit | per_hit;
    misaligned = (Addr[1:0] != 2'b00);
    illegal    = !mapped | (MemWrite & misaligned);
    wr_ok      = MemWrite & !illegal;
    reg_idx    = Addr[4:2];
    ram_idx    = Addr[AW+1:2];
  end

  // FIFO handshake; a push into a full FIFO still succeeds when the head leaves in the same cycle
  always_comb begin
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    pop        = !fifo_empty & tx_ready;
    push_req   = wr_ok & per_hit & (reg_idx == REG_CONSOLE);
    push_acc   = push_req & (!fifo_full | pop);
    count5     = 5'(count_q);
  end

  // Next-state for FIFO bookkeeping, timer and control; hardware sets win over software clears
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    timer_d = timer_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    irqen_d = irqen_q;

    if (push_acc) wptr_d = wptr_q + FPW'(1);
    if (pop)      rptr_d = rptr_q + FPW'(1);
    if (push_acc && !pop)      count_d = count_q + CW'(1);
    else if (!push_acc && pop) count_d = count_q - CW'(1);

    if (wr_ok && per_hit && reg_idx == REG_STATUS && WriteData[2]) ovf_d = 1'b0;
    if (push_req && !push_acc)                                    ovf_d = 1'b1;

    if (en_q) timer_d = timer_q + 32'd1;
    if (wr_ok && per_hit && reg_idx == REG_TIMER) timer_d = WriteData;
    if (wr_ok && per_hit && reg_idx == REG_CMP)   cmp_d   = WriteData;

    if (wr_ok && per_hit && reg_idx == REG_CTRL) begin
      en_d    = WriteData[0];
      irqen_d = WriteData[2];
      if (WriteData[1]) pend_d = 1'b0;
    end
    if (en_q && timer_q == cmp_q) pend_d = 1'b1;
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      timer_q   <= 32'd0;
      cmp_q     <= 32'hFFFF_FFFF;
      en_q      <= 1'b0;
      pend_q    <= 1'b0;
      irqen_q   <= 1'b0;
      irq_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      irqen_q   <= irqen_d;
      irq_q     <= pend_q & irqen_q;
      bus_err_q <= illegal;
    end
  end

  // RAM storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ok && ram_hit) ram_mem[ram_idx] <= WriteData;
  end

  // FIFO storage; entries outside head..tail are don't-care so no reset is needed
  always_ff @(posedge clk) begin
    if (push_acc) fifo_mem[wptr_q] <= WriteData[7:0];
  end

  // Zero-latency load path; unmapped addresses read as zero
  always_comb begin
    ReadData = 32'd0;
    if (ram_hit) begin
      ReadData = ram_mem[ram_idx];
    end else if (per_hit) begin
      case (reg_idx)
        REG_STATUS: ReadData = {24'd0, count5, ovf_q, fifo_full, fifo_empty};
        REG_TIMER:  ReadData = timer_q;
        REG_CMP:    ReadData = cmp_q;
        REG_CTRL:   ReadData = {29'd0, irqen_q, pend_q, en_q};
        default:    ReadData = 32'd0;
      endcase
    end
  end

  assign tx_data   = fifo_mem[rptr_q];
  assign tx_valid  = !fifo_empty;
  assign timer_irq = irq_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam logic [31:0] A_CONSOLE = 32'h8000_0000;
  localparam logic [31:0] A_STATUS  = 32'h8000_0004;
  localparam logic [31:0] A_TIMER   = 32'h8000_0008;
  localparam logic [31:0] A_CMP     = 32'h8000_000C;
  localparam logic [31:0] A_CTRL    = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        timer_irq;
  logic        bus_err;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  sb_q[$];
  int          model_count = 0;
  logic        model_ovf = 1'b0;
  logic [31:0] rd;

  data_mem_responder #(.DEPTH_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WriteData(WriteData), .MemWrite(MemWrite),
    .ReadData(ReadData), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .timer_irq(timer_irq), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    WriteData = d;
    MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    Addr = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Addr = a;
    MemWrite = 1'b0;
    #1;
    d = ReadData;
  endtask

  function automatic logic [31:0] status_exp();
    return {24'd0, 5'(model_count), model_ovf, model_count == 8, model_count == 0};
  endfunction

  // Scoreboard-side console push with no pop in the same cycle
  task automatic console_push(input logic [7:0] b);
    if (model_count < 8) begin
      sb_q.push_back(b);
      model_count++;
    end else begin
      model_ovf = 1'b1;
    end
    bus_write(A_CONSOLE, {24'd0, b});
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 40;
    tx_ready = 1'b1;
    #1;
    while (sb_q.size() > 0 && budget > 0) begin
      check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, tx_data}, {24'd0, sb_q.pop_front()});
      model_count--;
      step();
      budget--;
    end
    if (budget == 0) check({tag, "_budget"}, 32'd0, 32'd1);
    check({tag, "_empty"}, {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
  endtask

  initial begin
    int    budget;
    logic  seen;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    bus_read(A_TIMER, rd);  check("rst_timer", rd, 32'd0);
    bus_read(A_CMP, rd);    check("rst_cmp", rd, 32'hFFFF_FFFF);
    bus_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'd0);
    bus_read(A_STATUS, rd); check("rst_status", rd, 32'h0000_0001);
    Addr = 32'd0;
    reset = 1'b1;
    step();

    // RAM write/read and misaligned read
    bus_write(32'h0000_0000, 32'h1234_5678);
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    bus_read(32'h0000_0010, rd); check("ram_rd", rd, 32'hDEAD_BEEF);
    bus_read(32'h0000_0012, rd); check("ram_misalign_rd", rd, 32'hDEAD_BEEF);
    step();
    check("misalign_rd_no_err", {31'd0, bus_err}, 32'd0);
    bus_read(32'h0000_00FC, rd);
    bus_write(32'h0000_00FC, 32'hA5A5_0001);
    bus_read(32'h0000_00FC, rd); check("ram_top_word", rd, 32'hA5A5_0001);

    // Illegal accesses
    bus_write(32'h4000_0000, 32'hBAD0_0001);
    check("unmapped_wr_err", {31'd0, bus_err}, 32'd1);
    step();
    check("unmapped_wr_err_pulse", {31'd0, bus_err}, 32'd0);
    bus_read(32'h0000_0000, rd); check("ram0_unchanged", rd, 32'h1234_5678);
    bus_write(32'h0000_0011, 32'hBAD0_0002);
    check("misalign_wr_err", {31'd0, bus_err}, 32'd1);
    bus_read(32'h0000_0010, rd); check("misalign_wr_dropped", rd, 32'hDEAD_BEEF);
    bus_read(32'h9000_0000, rd); check("unmapped_rd", rd, 32'd0);
    bus_read(32'h8000_0014, rd); check("unmapped_per_rd", rd, 32'd0);
    bus_read(32'h0000_0100, rd); check("past_ram_rd", rd, 32'd0);
    step();
    check("unmapped_rd_err", {31'd0, bus_err}, 32'd1);
    Addr = 32'd0;
    step();
    check("err_cleared", {31'd0, bus_err}, 32'd0);

    // FIFO fill and overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) console_push(8'(8'h41 + i));
    bus_read(A_STATUS, rd);  check("fifo_full_status", rd, 32'h0000_0046);
    check("fifo_full_status_model", rd, status_exp());
    check("fifo_head", {24'd0, tx_data}, 32'h41);
    bus_read(A_CONSOLE, rd); check("console_rd_zero", rd, 32'd0);
    Addr = 32'd0;
    drain("drain1");
    bus_read(A_STATUS, rd);  check("drained_status", rd, status_exp());

    // Push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) console_push(8'(8'h61 + i));
    bus_read(A_STATUS, rd);  check("refill_status", rd, status_exp());
    tx_ready = 1'b1;
    #1;
    check("pp_head", {24'd0, tx_data}, {24'd0, sb_q.pop_front()});
    sb_q.push_back(8'h55);
    bus_write(A_CONSOLE, 32'h0000_0055);
    tx_ready = 1'b0;
    bus_read(A_STATUS, rd);  check("pp_status", rd, 32'h0000_0046);
    bus_write(A_STATUS, 32'h0000_0004);
    model_ovf = 1'b0;
    bus_read(A_STATUS, rd);  check("ovf_clear", rd, 32'h0000_0042);
    Addr = 32'd0;
    drain("drain2");

    // Timer compare interrupt
    bus_write(A_CMP, 32'd5);
    bus_write(A_CTRL, 32'h5);
    budget = 20;
    seen = 1'b0;
    while (!seen && budget > 0) begin
      bus_read(A_CTRL, rd);
      if (rd[1]) begin
        seen = 1'b1;
        bus_read(A_TIMER, rd); check("pend_timer", rd, 32'd6);
        check("irq_lag", {31'd0, timer_irq}, 32'd0);
      end else begin
        bus_read(A_TIMER, rd);
        if (rd > 32'd5) check("pend_missed", rd, 32'd5);
        step();
        budget--;
      end
    end
    if (!seen) check("pend_timeout", 32'd0, 32'd1);
    step();
    check("irq_rise", {31'd0, timer_irq}, 32'd1);
    bus_write(A_CTRL, 32'h7);
    bus_read(A_CTRL, rd);    check("pend_clear", rd, 32'h5);
    step();
    check("irq_fall", {31'd0, timer_irq}, 32'd0);
    bus_write(A_TIMER, 32'hFFFF_FFFE);
    bus_read(A_TIMER, rd);   check("timer_wr", rd, 32'hFFFF_FFFE);
    step();
    bus_read(A_TIMER, rd);   check("timer_ff", rd, 32'hFFFF_FFFF);
    step();
    bus_read(A_TIMER, rd);   check("timer_wrap", rd, 32'd0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) console_push(8'(8'h30 + i));
    bus_write(A_CTRL, 32'h1);
    step();
    bus_read(A_TIMER, rd);
    if (rd == 32'd0) check("timer_running", rd, 32'd1);
    check("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_irq", {31'd0, timer_irq}, 32'd0);
    bus_read(A_TIMER, rd);  check("mid_rst_timer", rd, 32'd0);
    bus_read(A_CTRL, rd);   check("mid_rst_ctrl", rd, 32'd0);
    bus_read(A_STATUS, rd); check("mid_rst_status", rd, 32'h0000_0001);
    reset = 1'b1;
    sb_q.delete();
    model_count = 0;
    model_ovf = 1'b0;
    step();
    bus_read(32'h0000_0010, rd); check("ram_kept", rd, 32'hDEAD_BEEF);
    Addr = 32'd0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
